// File: rtl/vend_pkg.sv
// Shared types and encodings for the vending transaction controller.
package vend_pkg;

   localparam int unsigned CREDIT_W = 4;
   localparam int unsigned SUM_W    = CREDIT_W + 1;
   localparam int unsigned UNITS_W  = 3;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      DISPENSE,
      CHANGE,
      REFUND
   } state_t;

   localparam logic [1:0] COIN_25P  = 2'b00;
   localparam logic [1:0] COIN_50P  = 2'b01;
   localparam logic [1:0] COIN_1R   = 2'b10;
   localparam logic [1:0] COIN_NONE = 2'b11;

   localparam logic [1:0] SEL_NONE   = 2'b00;
   localparam logic [1:0] SEL_A      = 2'b01;
   localparam logic [1:0] SEL_B      = 2'b10;
   localparam logic [1:0] SEL_CANCEL = 2'b11;

   // Coin code to value in 25p units.
   function automatic logic [UNITS_W-1:0] coin_units(input logic [1:0] code);
      logic [UNITS_W-1:0] units;
      units = '0;
      case (code)
         COIN_25P: units = UNITS_W'(1);
         COIN_50P: units = UNITS_W'(2);
         COIN_1R:  units = UNITS_W'(4);
         default:  units = '0;
      endcase
      return units;
   endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit register: add with ceiling check, subtract price, decrement, reject flag.
module vend_credit
   import vend_pkg::*;
#(
   parameter int unsigned MAX_CREDIT = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                add_en,
   input  logic [UNITS_W-1:0]  add_val,
   input  logic                sub_en,
   input  logic [CREDIT_W-1:0] sub_val,
   input  logic                dec_en,
   input  logic                rej_force,
   output logic [CREDIT_W-1:0] credit,
   output logic                fits_c,
   output logic                coin_reject
);

   logic [SUM_W-1:0] sum_c;

   // One extra bit so the ceiling compare never sees a wrapped sum.
   assign sum_c  = SUM_W'(credit) + SUM_W'(add_val);
   assign fits_c = (sum_c <= SUM_W'(MAX_CREDIT));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         credit      <= '0;
         coin_reject <= 1'b0;
      end else begin
         coin_reject <= rej_force | (add_en & ~fits_c);
         if (add_en && fits_c) begin
            credit <= CREDIT_W'(sum_c);
         end else if (sub_en) begin
            credit <= credit - sub_val;
         end else if (dec_en) begin
            credit <= credit - CREDIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin collection, selection, dispenser
// handshake, and change/refund paid out one 25p unit per cycle.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int unsigned PRICE_A    = 4,
   parameter int unsigned PRICE_B    = 3,
   parameter int unsigned MAX_CREDIT = 8,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [1:0]          coin,
   input  logic [1:0]          sel,
   input  logic                disp_ack,
   output logic                disp_req,
   output logic                disp_item,
   output logic                chg_pulse,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                insufficient,
   output logic                vend_done,
   output logic                busy
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   state_t             state;
   logic [TMO_W-1:0]   tmo_cnt;

   logic                coin_vld_c;
   logic [UNITS_W-1:0]  coin_val_c;
   logic                sel_prod_c;
   logic [CREDIT_W-1:0] price_c;
   logic                afford_c;
   logic                fits_c;
   logic                add_en_c;
   logic                sub_en_c;
   logic                dec_en_c;
   logic                rej_force_c;

   assign coin_vld_c = (coin != COIN_NONE);
   assign coin_val_c = coin_units(coin);
   assign sel_prod_c = (sel != SEL_NONE) && (sel != SEL_CANCEL);
   assign price_c    = (sel == SEL_B) ? CREDIT_W'(PRICE_B) : CREDIT_W'(PRICE_A);
   assign afford_c   = (credit >= price_c);

   // Credit operations requested by the current state; a coin always wins over sel.
   always_comb begin
      add_en_c    = 1'b0;
      sub_en_c    = 1'b0;
      dec_en_c    = 1'b0;
      rej_force_c = 1'b0;
      case (state)
         IDLE, COLLECT: add_en_c    = coin_vld_c;
         default:       rej_force_c = coin_vld_c;
      endcase
      if (state == COLLECT && !coin_vld_c && sel_prod_c && afford_c) begin
         sub_en_c = 1'b1;
      end
      if ((state == CHANGE || state == REFUND) && credit != '0) begin
         dec_en_c = 1'b1;
      end
   end

   vend_credit #(
      .MAX_CREDIT (MAX_CREDIT)
   ) u_credit (
      .clock       (clock),
      .reset_n     (reset_n),
      .add_en      (add_en_c),
      .add_val     (coin_val_c),
      .sub_en      (sub_en_c),
      .sub_val     (price_c),
      .dec_en      (dec_en_c),
      .rej_force   (rej_force_c),
      .credit      (credit),
      .fits_c      (fits_c),
      .coin_reject (coin_reject)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         tmo_cnt      <= '0;
         disp_req     <= 1'b0;
         disp_item    <= 1'b0;
         chg_pulse    <= 1'b0;
         insufficient <= 1'b0;
         vend_done    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         chg_pulse    <= dec_en_c;
         insufficient <= 1'b0;
         vend_done    <= 1'b0;
         case (state)
            IDLE: begin
               if (coin_vld_c && fits_c) begin
                  state   <= COLLECT;
                  tmo_cnt <= '0;
               end
            end
            COLLECT: begin
               if (coin_vld_c && fits_c) begin
                  tmo_cnt <= '0;
               end else if (!coin_vld_c && sel == SEL_CANCEL) begin
                  state   <= REFUND;
                  busy    <= 1'b1;
                  tmo_cnt <= '0;
               end else if (!coin_vld_c && sel_prod_c && afford_c) begin
                  state     <= DISPENSE;
                  busy      <= 1'b1;
                  disp_req  <= 1'b1;
                  disp_item <= (sel == SEL_B);
                  tmo_cnt   <= '0;
               end else begin
                  // Idle cycle, rejected coin or short-credit selection.
                  if (!coin_vld_c && sel_prod_c) begin
                     insufficient <= 1'b1;
                  end
                  if (tmo_cnt >= TMO_W'(TIMEOUT - 1)) begin
                     state   <= REFUND;
                     busy    <= 1'b1;
                     tmo_cnt <= '0;
                  end else begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
               end
            end
            DISPENSE: begin
               if (disp_ack) begin
                  disp_req <= 1'b0;
                  state    <= CHANGE;
               end
            end
            CHANGE: begin
               if (credit == '0) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  vend_done <= 1'b1;
               end
            end
            REFUND: begin
               if (credit == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: per-cycle compare against a behavioural
// model plus hand-computed checkpoints along the transaction scenarios.
module tb_vend_sequencer;

   localparam int PRICE_A    = 4;
   localparam int PRICE_B    = 3;
   localparam int MAX_CREDIT = 8;
   localparam int TIMEOUT    = 255;

   localparam int PH_IDLE     = 0;
   localparam int PH_COLLECT  = 1;
   localparam int PH_DISPENSE = 2;
   localparam int PH_CHANGE   = 3;
   localparam int PH_REFUND   = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] coin = 2'b11;
   logic [1:0] sel = 2'b00;
   logic       disp_ack = 1'b0;
   logic       disp_req, disp_item, chg_pulse, coin_reject, insufficient, vend_done, busy;
   logic [3:0] credit;

   int n_checks = 0;
   int n_errors = 0;

   vend_sequencer #(
      .PRICE_A    (PRICE_A),
      .PRICE_B    (PRICE_B),
      .MAX_CREDIT (MAX_CREDIT),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .coin         (coin),
      .sel          (sel),
      .disp_ack     (disp_ack),
      .disp_req     (disp_req),
      .disp_item    (disp_item),
      .chg_pulse    (chg_pulse),
      .credit       (credit),
      .coin_reject  (coin_reject),
      .insufficient (insufficient),
      .vend_done    (vend_done),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Behavioural model, advanced on the same edges as the DUT.
   int m_phase, m_credit, m_timer;
   bit e_req, e_item, e_chg, e_rej, e_ins, e_done;

   task automatic model_tick();
      m_timer++;
      if (m_timer >= TIMEOUT) m_phase = PH_REFUND;
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = PH_IDLE; m_credit = 0; m_timer = 0;
         e_req = 0; e_item = 0; e_chg = 0; e_rej = 0; e_ins = 0; e_done = 0;
      end else begin
         bit has_coin;
         int v;
         int price;
         has_coin = (coin != 2'b11);
         v = has_coin ? (1 << coin) : 0;
         e_chg = 0; e_rej = 0; e_ins = 0; e_done = 0;
         case (m_phase)
            PH_IDLE, PH_COLLECT: begin
               if (has_coin && m_credit + v > MAX_CREDIT) begin
                  e_rej = 1;
                  if (m_phase == PH_COLLECT) model_tick();
               end else if (has_coin) begin
                  m_credit += v;
                  m_phase = PH_COLLECT;
                  m_timer = 0;
               end else if (m_phase == PH_COLLECT) begin
                  if (sel == 2'b11) begin
                     m_phase = PH_REFUND;
                  end else if (sel == 2'b01 || sel == 2'b10) begin
                     price = (sel == 2'b01) ? PRICE_A : PRICE_B;
                     if (m_credit >= price) begin
                        m_credit -= price;
                        e_item = (sel == 2'b10);
                        e_req = 1;
                        m_phase = PH_DISPENSE;
                     end else begin
                        e_ins = 1;
                        model_tick();
                     end
                  end else begin
                     model_tick();
                  end
               end
            end
            PH_DISPENSE: begin
               e_rej = has_coin;
               if (disp_ack) begin
                  e_req = 0;
                  m_phase = PH_CHANGE;
               end
            end
            default: begin
               e_rej = has_coin;
               if (m_credit > 0) begin
                  m_credit--;
                  e_chg = 1;
               end else begin
                  e_done = (m_phase == PH_CHANGE);
                  m_phase = PH_IDLE;
               end
            end
         endcase
      end
   end

   // Per-cycle comparison, half a period away from the active edge.
   always @(negedge clock) begin
      chk("credit", int'(credit), m_credit);
      chk("disp_req", int'(disp_req), int'(e_req));
      if (e_req) chk("disp_item", int'(disp_item), int'(e_item));
      chk("chg_pulse", int'(chg_pulse), int'(e_chg));
      chk("coin_reject", int'(coin_reject), int'(e_rej));
      chk("insufficient", int'(insufficient), int'(e_ins));
      chk("vend_done", int'(vend_done), int'(e_done));
      chk("busy", int'(busy), int'(m_phase == PH_DISPENSE || m_phase == PH_CHANGE ||
                                   m_phase == PH_REFUND));
   end

   task automatic step(input logic [1:0] c, input logic [1:0] s, input logic a);
      coin = c; sel = s; disp_ack = a;
      @(posedge clock);
      #1;
   endtask

   int pulses, dones;

   initial begin
      #2;
      chk("rst_credit", int'(credit), 0);
      chk("rst_outputs", int'({disp_req, chg_pulse, coin_reject, insufficient, vend_done, busy}), 0);
      #10 reset_n = 1'b1;

      // 1: four 25p coins, buy A at exact price, ack after 3 cycles.
      for (int i = 1; i <= 4; i++) begin
         step(2'b00, 2'b00, 1'b0);
         chk("t1_credit", int'(credit), i);
      end
      step(2'b11, 2'b01, 1'b0);
      chk("t1_req", int'(disp_req), 1);
      chk("t1_item", int'(disp_item), 0);
      chk("t1_credit_after_sel", int'(credit), 0);
      step(2'b11, 2'b00, 1'b0);
      step(2'b11, 2'b00, 1'b0);
      step(2'b11, 2'b00, 1'b1);
      chk("t1_req_drop", int'(disp_req), 0);
      step(2'b11, 2'b00, 1'b0);
      chk("t1_no_chg", int'(chg_pulse), 0);
      chk("t1_done", int'(vend_done), 1);
      step(2'b11, 2'b00, 1'b0);
      chk("t1_done_pulse", int'(vend_done), 0);

      // 2: one rupee, buy B, one unit of change.
      step(2'b10, 2'b00, 1'b0);
      step(2'b11, 2'b10, 1'b0);
      chk("t2_item", int'(disp_item), 1);
      chk("t2_credit", int'(credit), 1);
      step(2'b11, 2'b00, 1'b1);
      step(2'b11, 2'b00, 1'b0);
      chk("t2_chg", int'(chg_pulse), 1);
      chk("t2_credit0", int'(credit), 0);
      step(2'b11, 2'b00, 1'b0);
      chk("t2_done", int'(vend_done), 1);

      // 3: fill to the ceiling, overflow reject, cancel refunds all 8 units.
      step(2'b10, 2'b00, 1'b0);
      step(2'b10, 2'b00, 1'b0);
      chk("t3_credit8", int'(credit), 8);
      step(2'b01, 2'b00, 1'b0);
      chk("t3_reject", int'(coin_reject), 1);
      chk("t3_credit_held", int'(credit), 8);
      step(2'b11, 2'b11, 1'b0);
      chk("t3_busy", int'(busy), 1);
      pulses = 0; dones = 0;
      for (int i = 0; i < 10; i++) begin
         step(2'b11, 2'b00, 1'b0);
         if (chg_pulse) pulses++;
         if (vend_done) dones++;
      end
      chk("t3_pulses", pulses, 8);
      chk("t3_no_done", dones, 0);

      // 4: short credit, coin+sel collision, then a real purchase.
      step(2'b01, 2'b00, 1'b0);
      step(2'b11, 2'b01, 1'b0);
      chk("t4_insufficient", int'(insufficient), 1);
      chk("t4_credit", int'(credit), 2);
      step(2'b01, 2'b01, 1'b0);
      chk("t4_credit4", int'(credit), 4);
      chk("t4_no_req", int'(disp_req), 0);
      chk("t4_no_ins", int'(insufficient), 0);
      step(2'b11, 2'b01, 1'b0);
      chk("t4_req", int'(disp_req), 1);
      step(2'b01, 2'b00, 1'b1);
      chk("t4_busy_reject", int'(coin_reject), 1);
      step(2'b11, 2'b00, 1'b0);
      step(2'b11, 2'b00, 1'b0);

      // 5: timeout refund after TIMEOUT idle cycles.
      step(2'b00, 2'b00, 1'b0);
      for (int i = 0; i < TIMEOUT - 1; i++) step(2'b11, 2'b00, 1'b0);
      chk("t5_not_yet", int'(busy), 0);
      step(2'b11, 2'b00, 1'b0);
      chk("t5_refund", int'(busy), 1);
      step(2'b11, 2'b00, 1'b0);
      chk("t5_chg", int'(chg_pulse), 1);
      step(2'b11, 2'b00, 1'b0);
      chk("t5_idle", int'(busy), 0);
      chk("t5_no_done", int'(vend_done), 0);

      // 6: asynchronous reset mid-dispense discards credit.
      step(2'b10, 2'b00, 1'b0);
      step(2'b01, 2'b00, 1'b0);
      step(2'b11, 2'b10, 1'b0);
      chk("t6_credit3", int'(credit), 3);
      step(2'b11, 2'b00, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_req_async", int'(disp_req), 0);
      chk("t6_credit_async", int'(credit), 0);
      chk("t6_busy_async", int'(busy), 0);
      @(negedge clock);
      reset_n = 1'b1;
      step(2'b00, 2'b00, 1'b0);
      chk("t6_after", int'(credit), 1);
      step(2'b11, 2'b00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
